// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: default widths, complex sample type and
// the saturating narrowing helper used by the butterfly pipelines.
package fft_pkg;

    localparam int unsigned FFT_DATA_W    = 16;
    localparam int unsigned FFT_FRAC_BITS = 15;
    // Twiddle carries one extra integer bit so that +1.0 is representable.
    localparam int unsigned TWID_W        = FFT_FRAC_BITS + 2;
    // Common width the saturation helper works in; wide enough for any stage.
    localparam int unsigned SAT_IN_W      = 64;

    // Complex sample: [0] = real, [1] = imaginary.
    typedef logic [1:0][FFT_DATA_W-1:0] cplx_t;

    // Clamp a signed value to the range of a w-bit signed number.
    function automatic logic signed [SAT_IN_W-1:0] sat_to_width(
        input  logic signed [SAT_IN_W-1:0] x,
        input  int unsigned                w,
        output logic                       clamped
    );
        logic signed [SAT_IN_W-1:0] hi;
        logic signed [SAT_IN_W-1:0] lo;
        logic signed [SAT_IN_W-1:0] res;
        hi      = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
        lo      = -hi - 64'sd1;
        res     = x;
        clamped = 1'b0;
        if (x > hi) begin
            res     = hi;
            clamped = 1'b1;
        end else if (x < lo) begin
            res     = lo;
            clamped = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/cplx_conj_mul.sv
// Registered conjugate multiply p = d * conj(t), scaled down by FRAC_BITS
// with an arithmetic shift (floor). Two register levels: products, then
// sum/shift. All registers advance only when en_i is high.
//   clk_i : clock
//   en_i  : pipeline advance
//   d_i   : complex data, A_W-bit signed components ([0]=re, [1]=im)
//   t_i   : complex twiddle, T_W-bit signed components
//   p_o   : complex result, P_W-bit signed components (2 cycles after d_i/t_i)
module cplx_conj_mul #(
    parameter  int unsigned A_W       = 17,
    parameter  int unsigned T_W       = 17,
    parameter  int unsigned FRAC_BITS = 15,
    localparam int unsigned P_W       = A_W + T_W + 1 - FRAC_BITS
) (
    input  logic                clk_i,
    input  logic                en_i,
    input  logic [1:0][A_W-1:0] d_i,
    input  logic [1:0][T_W-1:0] t_i,
    output logic [1:0][P_W-1:0] p_o
);

    localparam int unsigned PRD_W  = A_W + T_W;
    localparam int unsigned FULL_W = PRD_W + 1;

    logic signed [A_W-1:0]    w_d_re, w_d_im;
    logic signed [T_W-1:0]    w_t_re, w_t_im;
    logic signed [PRD_W-1:0]  w_p_rr, w_p_ii, w_p_ir, w_p_ri;
    logic signed [PRD_W-1:0]  r_p_rr, r_p_ii, r_p_ir, r_p_ri;
    logic signed [FULL_W-1:0] w_re, w_im;
    logic [1:0][P_W-1:0]      r_p;

    // Full-precision partial products of d * conj(t).
    always_comb begin
        w_d_re = $signed(d_i[0]);
        w_d_im = $signed(d_i[1]);
        w_t_re = $signed(t_i[0]);
        w_t_im = $signed(t_i[1]);
        w_p_rr = PRD_W'(w_d_re) * PRD_W'(w_t_re);
        w_p_ii = PRD_W'(w_d_im) * PRD_W'(w_t_im);
        w_p_ir = PRD_W'(w_d_im) * PRD_W'(w_t_re);
        w_p_ri = PRD_W'(w_d_re) * PRD_W'(w_t_im);
    end

    // Product register level.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            r_p_rr <= w_p_rr;
            r_p_ii <= w_p_ii;
            r_p_ir <= w_p_ir;
            r_p_ri <= w_p_ri;
        end
    end

    // Conjugate combine; the sum needs one bit more than a product.
    always_comb begin
        w_re = FULL_W'(r_p_rr) + FULL_W'(r_p_ii);
        w_im = FULL_W'(r_p_ir) - FULL_W'(r_p_ri);
    end

    // Result register level: floor scaling by the twiddle's fraction bits.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            r_p[0] <= P_W'(w_re >>> FRAC_BITS);
            r_p[1] <= P_W'(w_im >>> FRAC_BITS);
        end
    end

    assign p_o = r_p;

endmodule

// File: rtl/butterfly_inv_pipe.sv
// Pipelined inverse radix-2 butterfly: A = A' + B', B = conj(W) * (A' - B'),
// both saturated to DATA_WIDTH. Valid/ready stream in and out; the whole
// pipeline advances together whenever the output register is free.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   in_valid_i/in_ready_o  : input handshake (in_ready_o is combinational)
//   twid_i, a_i, b_i       : W, A', B' ([0]=re, [1]=im)
//   out_valid_o/out_ready_i: output handshake (out_valid_o registered)
//   a_o, b_o               : A, B
//   out_sat_o              : some component of the current output clamped
//   sat_o, clr_i           : sticky saturation flag and its synchronous clear
module butterfly_inv_pipe
    import fft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FFT_DATA_W,
    parameter int unsigned FRAC_BITS  = FFT_FRAC_BITS
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic signed [1:0][FRAC_BITS+1:0]   twid_i,
    input  logic signed [1:0][DATA_WIDTH-1:0]  a_i,
    input  logic signed [1:0][DATA_WIDTH-1:0]  b_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic signed [1:0][DATA_WIDTH-1:0]  a_o,
    output logic signed [1:0][DATA_WIDTH-1:0]  b_o,
    output logic                               out_sat_o,
    output logic                               sat_o,
    input  logic                               clr_i
);

    localparam int unsigned T_W    = FRAC_BITS + 2;
    localparam int unsigned SUM_W  = DATA_WIDTH + 1;
    localparam int unsigned PROD_W = SUM_W + T_W + 1 - FRAC_BITS;

    logic                         w_en;
    logic                         r_v_s1, r_v_m1, r_v_m2, r_v_out;
    logic [1:0][SUM_W-1:0]        r_s_s1, r_d_s1;
    logic [1:0][T_W-1:0]          r_t_s1;
    logic [1:0][SUM_W-1:0]        r_s_m1, r_s_m2;
    logic [1:0][PROD_W-1:0]       w_p;
    logic [1:0][DATA_WIDTH-1:0]   w_a_sat, w_b_sat;
    logic                         w_sat_any;
    logic signed [SAT_IN_W-1:0]   w_tmp;
    logic                         w_clamp;
    logic [1:0][DATA_WIDTH-1:0]   r_a, r_b;
    logic                         r_out_sat, r_sat;

    // Everything moves when the output register is empty or being drained.
    assign w_en       = !r_v_out || out_ready_i;
    assign in_ready_o = w_en;

    // Valid bits are the only state that must reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_v_s1  <= 1'b0;
            r_v_m1  <= 1'b0;
            r_v_m2  <= 1'b0;
            r_v_out <= 1'b0;
        end else if (w_en) begin
            r_v_s1  <= in_valid_i;
            r_v_m1  <= r_v_s1;
            r_v_m2  <= r_v_m1;
            r_v_out <= r_v_m2;
        end
    end

    // S1: exact sum and difference, twiddle travels alongside.
    always_ff @(posedge clk_i) begin
        if (w_en) begin
            for (int i = 0; i < 2; i++) begin
                r_s_s1[i] <= SUM_W'($signed(a_i[i])) + SUM_W'($signed(b_i[i]));
                r_d_s1[i] <= SUM_W'($signed(a_i[i])) - SUM_W'($signed(b_i[i]));
            end
            r_t_s1 <= twid_i;
        end
    end

    // S2: conjugate multiply of the difference; the sum is delayed to match.
    cplx_conj_mul #(
        .A_W       (SUM_W),
        .T_W       (T_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_conj_mul (
        .clk_i (clk_i),
        .en_i  (w_en),
        .d_i   (r_d_s1),
        .t_i   (r_t_s1),
        .p_o   (w_p)
    );

    always_ff @(posedge clk_i) begin
        if (w_en) begin
            r_s_m1 <= r_s_s1;
            r_s_m2 <= r_s_m1;
        end
    end

    // S3: clamp all four components, note whether any clamped.
    always_comb begin
        w_a_sat   = '0;
        w_b_sat   = '0;
        w_sat_any = 1'b0;
        w_tmp     = '0;
        w_clamp   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            w_tmp      = sat_to_width(SAT_IN_W'($signed(r_s_m2[i])), DATA_WIDTH, w_clamp);
            w_a_sat[i] = DATA_WIDTH'(w_tmp);
            w_sat_any  = w_sat_any | w_clamp;
            w_tmp      = sat_to_width(SAT_IN_W'($signed(w_p[i])), DATA_WIDTH, w_clamp);
            w_b_sat[i] = DATA_WIDTH'(w_tmp);
            w_sat_any  = w_sat_any | w_clamp;
        end
    end

    // Output register: held while stalled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a       <= '0;
            r_b       <= '0;
            r_out_sat <= 1'b0;
        end else if (w_en) begin
            r_a       <= w_a_sat;
            r_b       <= w_b_sat;
            r_out_sat <= w_sat_any;
        end
    end

    // Sticky flag: a saturating beat leaving the block beats a clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sat <= 1'b0;
        end else begin
            r_sat <= (r_sat && !clr_i) || (r_v_out && out_ready_i && r_out_sat);
        end
    end

    assign out_valid_o = r_v_out;
    assign a_o         = r_a;
    assign b_o         = r_b;
    assign out_sat_o   = r_out_sat;
    assign sat_o       = r_sat;

endmodule
